sr_flipflop_bank: RTL and testbench

SR_FLIPFLOP_BANK -- requirements
Module: sr_flipflop

---
 rtl/sr_flipflop_bank_pkg.sv | 38 +++
 rtl/sr_flipflop_bank_cell.sv | 30 +++
 rtl/sr_flipflop_bank.sv | 34 +++
 tb/tb_sr_flipflop_bank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_flipflop_bank_pkg.sv
// Shared types for the SR flip-flop bank: the S=R=1 resolution mode and
// the per-bit next-state function used by every cell.
package sr_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SET    = 2'd1,
        RESET  = 2'd2,
        TOGGLE = 2'd3
    } sr11_mode_e;

    function automatic logic sr_next(
        input logic       q,
        input logic       s,
        input logic       r,
        input sr11_mode_e mode
    );
        logic nq;
        nq = q;
        unique case ({s, r})
            2'b00: nq = q;
            2'b10: nq = 1'b1;
            2'b01: nq = 1'b0;
            2'b11: begin
                unique case (mode)
                    HOLD:    nq = q;
                    SET:     nq = 1'b1;
                    RESET:   nq = 1'b0;
                    TOGGLE:  nq = ~q;
                    default: nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_flipflop_bank_cell.sv
// One SR bit: a state flop and a flag flop that marks an S=R=1 sample.
// Qn is a pure inversion so it tracks Q through reset with no clock.
module sr_cell
    import sr_pkg::*;
#(
    parameter sr11_mode_e SR11_MODE = HOLD,
    parameter logic       RST_VAL   = 1'b0
) (
    input  logic S,
    input  logic R,
    input  logic clk,
    output logic Q,
    output logic Qn,
    input  logic rst_n,
    output logic invalid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q       <= RST_VAL;
            invalid <= 1'b0;
        end else begin
            Q       <= sr_next(Q, S, R, SR11_MODE);
            invalid <= S & R;
        end
    end

    assign Qn = ~Q;

endmodule

// File: rtl/sr_flipflop_bank.sv
// Bank of WIDTH independent SR flip-flops sharing clock and async reset.
// The first five ports keep the classic S, R, clk, Q, Qn positional order.
module sr_flipflop_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter sr11_mode_e       SR11_MODE = HOLD
) (
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clk,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    input  logic             rst_n,
    output logic [WIDTH-1:0] invalid
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_cell #(
            .SR11_MODE (SR11_MODE),
            .RST_VAL   (RST_VAL[i])
        ) u_cell (
            .S       (S[i]),
            .R       (R[i]),
            .clk     (clk),
            .Q       (Q[i]),
            .Qn      (Qn[i]),
            .rst_n   (rst_n),
            .invalid (invalid[i])
        );
    end

endmodule

// File: tb/tb_sr_flipflop_bank.sv
// Bench for sr_flipflop_bank: four 4-bit instances, one per S=R=1 mode,
// driven in parallel and checked against a table plus a behavioural model.
module tb_sr_flipflop_bank;
    import sr_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] S;
    logic [3:0] R;
    logic [3:0] q   [4];
    logic [3:0] qn  [4];
    logic [3:0] inv [4];

    localparam logic [3:0] RV0 = 4'b0000;
    localparam logic [3:0] RV1 = 4'b1111;
    localparam logic [3:0] RV2 = 4'b0000;
    localparam logic [3:0] RV3 = 4'b0110;

    sr_flipflop_bank #(.WIDTH(4), .RST_VAL(RV0), .SR11_MODE(HOLD)) u_hold (
        .S(S), .R(R), .clk(clk), .Q(q[0]), .Qn(qn[0]), .rst_n(rst_n), .invalid(inv[0]));
    sr_flipflop_bank #(.WIDTH(4), .RST_VAL(RV1), .SR11_MODE(TOGGLE)) u_tog (
        .S(S), .R(R), .clk(clk), .Q(q[1]), .Qn(qn[1]), .rst_n(rst_n), .invalid(inv[1]));
    sr_flipflop_bank #(.WIDTH(4), .RST_VAL(RV2), .SR11_MODE(SET)) u_set (
        .S(S), .R(R), .clk(clk), .Q(q[2]), .Qn(qn[2]), .rst_n(rst_n), .invalid(inv[2]));
    sr_flipflop_bank #(.WIDTH(4), .RST_VAL(RV3), .SR11_MODE(RESET)) u_rst (
        .S(S), .R(R), .clk(clk), .Q(q[3]), .Qn(qn[3]), .rst_n(rst_n), .invalid(inv[3]));

    typedef struct packed {
        logic [3:0][3:0] q;
        logic [3:0][3:0] inv;
    } exp_t;

    typedef struct {
        logic [3:0] s;
        logic [3:0] r;
        logic [3:0] q_hold;
        logic [3:0] inv_hold;
    } vec_t;

    exp_t       sb[$];
    logic [3:0] mq   [4];
    logic [3:0] minv;
    int         errors = 0;
    int         checks = 0;

    function automatic logic [3:0] model_next(logic [3:0] qc, logic [3:0] s,
                                              logic [3:0] r, int mode);
        logic [3:0] n;
        for (int b = 0; b < 4; b++) begin
            case ({s[b], r[b]})
                2'b10:   n[b] = 1'b1;
                2'b01:   n[b] = 1'b0;
                2'b11:   n[b] = (mode == 1) ? ~qc[b] : (mode == 2) ? 1'b1 :
                                (mode == 3) ? 1'b0 : qc[b];
                default: n[b] = qc[b];
            endcase
        end
        return n;
    endfunction

    task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        string names[4] = '{"hold", "toggle", "set", "reset"};
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("%s %s Q", tag, names[k]), q[k], e.q[k]);
            cmp($sformatf("%s %s Qn", tag, names[k]), qn[k], ~e.q[k]);
            cmp($sformatf("%s %s invalid", tag, names[k]), inv[k], e.inv[k]);
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.q[k]   = mq[k];
            e.inv[k] = minv;
        end
        return e;
    endfunction

    task automatic load_reset_model();
        mq[0] = RV0; mq[1] = RV1; mq[2] = RV2; mq[3] = RV3;
        minv  = 4'b0000;
    endtask

    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
        #1;
    endtask

    // Drive one vector, queue its expectation, clock, then pop and compare.
    task automatic step(input string tag, input logic [3:0] s, input logic [3:0] r,
                        input bit use_tab, input logic [3:0] tq, input logic [3:0] tinv);
        exp_t e;
        S = s;
        R = r;
        for (int k = 0; k < 4; k++) mq[k] = model_next(mq[k], s, r, k);
        minv = s & r;
        e = model_exp();
        if (use_tab) begin
            e.q[0]   = tq;
            e.inv[0] = tinv;
        end
        sb.push_back(e);
        tick();
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check_all(tag, sb.pop_front());
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'b1010, 4'b0101, 4'b1010, 4'b0000};
        vecs[1] = '{4'b0000, 4'b0000, 4'b1010, 4'b0000};
        vecs[2] = '{4'b0101, 4'b0000, 4'b1111, 4'b0000};
        vecs[3] = '{4'b0000, 4'b0011, 4'b1100, 4'b0000};
        vecs[4] = '{4'b1001, 4'b1001, 4'b1100, 4'b1001};
        vecs[5] = '{4'b0000, 4'b0000, 4'b1100, 4'b0000};
        vecs[6] = '{4'b1111, 4'b1111, 4'b1100, 4'b1111};
        vecs[7] = '{4'b1111, 4'b1111, 4'b1100, 4'b1111};
        vecs[8] = '{4'b0001, 4'b1110, 4'b0001, 4'b0000};
        vecs[9] = '{4'b0110, 4'b0010, 4'b0101, 4'b0010};

        clk   = 1'b0;
        rst_n = 1'b1;
        S     = 4'b0000;
        R     = 4'b0000;

        // Reset with the clock idle must take effect immediately.
        #2 rst_n = 1'b0;
        #1;
        load_reset_model();
        check_all("reset_noclk", model_exp());

        S = 4'b1111;
        tick();
        tick();
        check_all("edges_in_reset", model_exp());

        S = 4'b0000;
        #2 rst_n = 1'b1;
        #1;
        check_all("release_no_edge", model_exp());

        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].s, vecs[i].r, 1'b1,
                 vecs[i].q_hold, vecs[i].inv_hold);

        // Level changes on S/R away from the rising edge must not matter.
        step("pre_sens", 4'b0000, 4'b0000, 1'b0, 4'b0, 4'b0);
        S = 4'b1111; #2 R = 4'b1111; #2 S = 4'b0000; #2 R = 4'b0000; #1;
        check_all("clk_low_wiggle", model_exp());
        #2 clk = 1'b1;
        #1;
        S = 4'b1111; #2 R = 4'b0101; #2 S = 4'b0000; #2 R = 4'b1111; #1;
        check_all("clk_high_wiggle", model_exp());
        clk = 1'b0;
        S = 4'b0000;
        R = 4'b0000;
        #2;

        // Repeated S=R=1: toggle instance inverts every edge, invalid stays up.
        step("toggle_a", 4'b1111, 4'b1111, 1'b0, 4'b0, 4'b0);
        step("toggle_b", 4'b1111, 4'b1111, 1'b0, 4'b0, 4'b0);
        step("toggle_c", 4'b0011, 4'b0011, 1'b0, 4'b0, 4'b0);
        step("invalid_clear", 4'b0000, 4'b0000, 1'b0, 4'b0, 4'b0);

        // Asynchronous reset between edges overrides a pending set.
        step("preset_all", 4'b1111, 4'b0000, 1'b0, 4'b0, 4'b0);
        S = 4'b1111;
        #3 rst_n = 1'b0;
        #1;
        load_reset_model();
        check_all("async_mid", model_exp());
        tick();
        tick();
        check_all("set_during_reset", model_exp());
        #2 rst_n = 1'b1;
        #1;
        check_all("after_release", model_exp());
        step("first_edge_set", 4'b1111, 4'b0000, 1'b0, 4'b0, 4'b0);
        step("clear_low", 4'b0000, 4'b0011, 1'b0, 4'b0, 4'b0);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
